// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter decoder: FSM state encoding
// and the rotate-right step that defines the ring sequence.
package ring_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } ring_state_t;

  localparam int RING_MAX_W = 64;

  // Rotate the low `width` bits of `word` right by one; bits above `width` must be zero.
  function automatic logic [RING_MAX_W-1:0] ring_rotr(input logic [RING_MAX_W-1:0] word,
                                                      input int width);
    logic [RING_MAX_W-1:0] r;
    r = word >> 1;
    r[width-1] = word[0];
    return r;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and one-hot-to-binary encoder; idx_o is forced
// to zero whenever the word is not exactly one-hot.
module ring_onehot_enc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         ring_i,
  output logic                     onehot_o,
  output logic [$clog2(WIDTH)-1:0] idx_o
);

  localparam int IW = $clog2(WIDTH);

  logic          seen;
  logic          multi;
  logic [IW-1:0] pos;

  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    pos   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_i[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        pos   = IW'(i);
      end
    end
    onehot_o = seen & ~multi;
    idx_o    = onehot_o ? pos : '0;
  end

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter decoder: tracks a rotating one-hot word, locks after a run of
// correct samples, counts laps and flags sequence violations.
//
//   state  | meaning
//   HUNT   | waiting for any one-hot sample to seed the expected word
//   SYNC   | counting consecutive correct samples toward LOCK_COUNT
//   LOCKED | tracking the ring, counting laps on the start pattern
//   FAULT  | violation seen while locked; decode only until err_clr
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int LAP_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     err,
  output logic                     err_sticky,
  output logic [LAP_W-1:0]         lap_cnt,
  output logic                     lap_pulse
);

  localparam int IW = $clog2(WIDTH);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] START = {1'b1, {(WIDTH-1){1'b0}}};

  ring_state_t      state_q, state_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic             lap_pulse_q, lap_pulse_d;

  logic             onehot;
  logic [IW-1:0]    enc_idx;
  logic [WIDTH-1:0] rot_in;
  logic [WIDTH-1:0] rot_exp;
  logic [MW:0]      match_inc;

  ring_onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .ring_i   (ring_in),
    .onehot_o (onehot),
    .idx_o    (enc_idx)
  );

  assign rot_in    = WIDTH'(ring_rotr(RING_MAX_W'(ring_in), WIDTH));
  assign rot_exp   = WIDTH'(ring_rotr(RING_MAX_W'(exp_q), WIDTH));
  assign match_inc = {1'b0, match_q} + (MW+1)'(1);

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    exp_d        = exp_q;
    idx_d        = idx_q;
    idx_valid_d  = idx_valid_q;
    err_d        = 1'b0;
    err_sticky_d = err_clr ? 1'b0 : err_sticky_q;
    lap_cnt_d    = lap_cnt_q;
    lap_pulse_d  = 1'b0;

    if (en) begin
      idx_d       = enc_idx;
      idx_valid_d = onehot;
      unique case (state_q)
        HUNT: begin
          if (onehot) begin
            exp_d   = rot_in;
            match_d = MW'(1);
            state_d = (LOCK_COUNT == 1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (ring_in == exp_q) begin
            match_d = match_inc[MW-1:0];
            exp_d   = rot_exp;
            if (match_inc >= (MW+1)'(LOCK_COUNT)) state_d = LOCKED;
          end else if (onehot) begin
            match_d = MW'(1);
            exp_d   = rot_in;
          end else begin
            state_d = HUNT;
            match_d = '0;
            exp_d   = START;
          end
        end
        LOCKED: begin
          if (ring_in == exp_q) begin
            exp_d = rot_exp;
            if (ring_in == START) begin
              lap_cnt_d   = lap_cnt_q + LAP_W'(1);
              lap_pulse_d = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = FAULT;
          end
        end
        FAULT: ;
        default: state_d = HUNT;
      endcase
    end

    if (state_q == FAULT && err_clr) begin
      state_d   = HUNT;
      match_d   = '0;
      exp_d     = START;
      lap_cnt_d = '0;
    end

    // A new violation outranks a simultaneous clear.
    if (err_d) err_sticky_d = 1'b1;

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      match_q      <= '0;
      exp_q        <= START;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      lap_cnt_q    <= '0;
      lap_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      exp_q        <= exp_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      lap_cnt_q    <= lap_cnt_d;
      lap_pulse_q  <= lap_pulse_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign lap_cnt    = lap_cnt_q;
  assign lap_pulse  = lap_pulse_q;

endmodule
